// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller for the target shooting game.
// Sequences one game of SHOTS_PER_GAME shots. For each shot it has target_gen
// load a target, times the aiming window in video frames, resolves the shot
// against the cursor and advances target_gen for the next shot.
//
// Ports:
//   clk            - system clock
//   rst_n          - asynchronous active-low reset
//   ena            - global enable; low freezes every register
//   frame_tick     - one-cycle pulse per video frame
//   start_btn      - debounced start level; rising edge starts a game
//   fire_btn       - debounced fire level; rising edge fires
//   cursor_x/y     - player cursor position
//   target_x/y     - current target from target_gen
//   start_new_game - pulse; loads the target registers in target_gen
//   result_valid   - pulse; one shot resolved, advances the target_gen RNG
//   hit            - result of the last resolved shot, held until the next one
//   score          - hits this game
//   shots_left     - shots remaining in this game
//   round_active   - high while aiming
//   game_over      - high once the game has ended
module round_sequencer #(
    parameter int SHOTS_PER_GAME = 8,
    parameter int ROUND_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       fire_btn,
    input  logic [4:0] cursor_x,
    input  logic [4:0] cursor_y,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic       start_new_game,
    output logic       result_valid,
    output logic       hit,
    output logic [3:0] score,
    output logic [3:0] shots_left,
    output logic       round_active,
    output logic       game_over
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_AIM     = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_GAME);
    localparam logic [7:0] TIMER_LAST = 8'(ROUND_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] score_q, score_d;
    logic [3:0] shots_left_q, shots_left_d;
    logic       hit_q, hit_d;
    logic       start_q, start_d;
    logic       fire_q, fire_d;

    logic       start_rise_s;
    logic       fire_rise_s;
    logic       on_target_s;
    logic       last_shot_s;

    assign start_rise_s = start_btn & ~start_q;
    assign fire_rise_s  = fire_btn & ~fire_q;
    assign on_target_s  = (cursor_x == target_x) && (cursor_y == target_y);
    assign last_shot_s  = (shots_left_q == 4'd1);

    // Next-state and datapath logic; everything holds while ena is low.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        score_d      = score_q;
        shots_left_d = shots_left_q;
        hit_d        = hit_q;
        start_d      = start_q;
        fire_d       = fire_q;

        if (ena) begin
            start_d = start_btn;
            fire_d  = fire_btn;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_rise_s) begin
                        score_d      = 4'd0;
                        shots_left_d = SHOTS_INIT;
                        state_d      = ST_LOAD;
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_LOAD: begin
                    state_d = ST_SETTLE;
                end

                // One cycle for the freshly loaded target to become visible.
                ST_SETTLE: begin
                    timer_d = 8'd0;
                    state_d = ST_AIM;
                end

                // Fire has priority over a timeout landing in the same cycle.
                ST_AIM: begin
                    if (fire_rise_s) begin
                        hit_d   = on_target_s;
                        state_d = ST_RESOLVE;
                    end else if (frame_tick) begin
                        if (timer_q == TIMER_LAST) begin
                            hit_d   = 1'b0;
                            state_d = ST_RESOLVE;
                        end else begin
                            timer_d = timer_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_AIM;
                    end
                end

                // hit_q already holds this shot's result; score cannot exceed
                // SHOTS_PER_GAME so no saturation is needed.
                ST_RESOLVE: begin
                    score_d      = score_q + {3'd0, hit_q};
                    shots_left_d = shots_left_q - 4'd1;
                    if (last_shot_s) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers; edge history resets high so a button
    // held through reset does not count as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            score_q      <= 4'd0;
            shots_left_q <= SHOTS_INIT;
            hit_q        <= 1'b0;
            start_q      <= 1'b1;
            fire_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score_q      <= score_d;
            shots_left_q <= shots_left_d;
            hit_q        <= hit_d;
            start_q      <= start_d;
            fire_q       <= fire_d;
        end
    end

    // Strobes are decodes of the state register gated by ena, so a state
    // frozen by ena low cannot repeat its pulse.
    assign start_new_game = ena & ((state_q == ST_LOAD) ||
                                   ((state_q == ST_RESOLVE) && !last_shot_s));
    assign result_valid   = ena & (state_q == ST_RESOLVE);
    assign round_active   = (state_q == ST_AIM);
    assign game_over      = (state_q == ST_OVER);
    assign hit            = hit_q;
    assign score          = score_q;
    assign shots_left     = shots_left_q;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller for the target shooting game. Sequences one game of `SHOTS_PER_GAME` shots: it commands `target_gen` to load a target, times the aiming window, resolves each shot against the cursor, and advances the target generator between shots. It sits between the debounced player inputs/cursor logic and `target_gen`, and exports score and status to the display path.

## Interface
Parameters:
- `SHOTS_PER_GAME`, 8: shots per game; legal range 1..15.
- `ROUND_FRAMES`, 180: aiming window length in `frame_tick` pulses; legal range 1..255.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; low freezes every register.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: debounced level; rising edge starts a game.
- `fire_btn` in 1: debounced level; rising edge fires.
- `cursor_x`, `cursor_y` in 5 each: player cursor position.
- `target_x`, `target_y` in 5 each: current target from `target_gen`.
- `start_new_game` out 1: pulse; loads target registers in `target_gen`.
- `result_valid` out 1: pulse; one shot resolved; also advances the `target_gen` RNG.
- `hit` out 1: result of last resolved shot; held until the next result.
- `score` out 4: hits this game.
- `shots_left` out 4: shots remaining.
- `round_active` out 1: high in AIM.
- `game_over` out 1: high in OVER.

## Operation
- Edge detectors: `start_rise = start_btn & ~start_q`, `fire_rise = fire_btn & ~fire_q`; `start_q` and `fire_q` reset to 1, so a button held through reset produces no edge.
- States: IDLE, LOAD, SETTLE, AIM, RESOLVE, OVER.
- IDLE: on `start_rise`, clear score, set `shots_left = SHOTS_PER_GAME`, go to LOAD.
- LOAD: assert `start_new_game` with `result_valid = 0`; the target loads from the current RNG state and the RNG holds. Go to SETTLE.
- SETTLE: clear the frame timer. Go to AIM. This state gives the new target one cycle to become visible.
- AIM: `round_active = 1`.
  - On `fire_rise`: register `hit_next = (cursor_x == target_x) && (cursor_y == target_y)` and go to RESOLVE.
  - On `frame_tick` with timer == `ROUND_FRAMES-1`: register `hit_next = 0` (timeout miss) and go to RESOLVE.
  - On any other `frame_tick`: increment the timer.
  - If `fire_rise` and timeout occur in the same cycle, the fire is evaluated.
- RESOLVE: assert `result_valid`, drive `hit`, `score += hit`, `shots_left -= 1`.
  - If `shots_left == 1` on entry: `start_new_game = 0`, go to OVER.
  - Otherwise: also assert `start_new_game` in the same cycle. The RNG advances and the new target loads. Go to SETTLE.
- OVER: `game_over = 1`; `score` and `hit` are held. On `start_rise`, clear score, set `shots_left = SHOTS_PER_GAME`, go to LOAD.
- Ignored events: `fire_rise` outside AIM; `start_rise` outside IDLE/OVER.
- `ena` low: state, timer, score, `shots_left`, `hit` and edge history all hold. `start_new_game` and `result_valid` are state decodes ANDed with `ena`, so a frozen RESOLVE or LOAD never pulses twice.
- Width rules: score never exceeds `SHOTS_PER_GAME`, so no saturation is needed. Timer is 8 bits and compared for equality.

## Timing
- Reset (async assert, sync release by upstream):
  - State IDLE, timer 0.
  - `start_new_game`, `result_valid`, `hit`, `score`, `round_active`, `game_over` = 0.
  - `shots_left = SHOTS_PER_GAME`.
- Reset mid-game: returns to IDLE immediately; no `result_valid` is issued for the interrupted shot.
- Start, with `start_rise` in cycle k:
  - LOAD in k+1 (`start_new_game` high).
  - SETTLE in k+2, with the new target visible.
  - AIM in k+3.
- Shot, with `fire_rise` in cycle k (AIM):
  - RESOLVE in k+1: `result_valid` and `hit` high.
  - `score` and `shots_left` update visible in k+2; SETTLE in k+2 with the new target.
  - AIM in k+3.
- Timeout: the `ROUND_FRAMES`-th `frame_tick` seen in AIM (cycle k) gives RESOLVE in k+1.
- Game end: the last RESOLVE is followed by OVER in the next cycle; `game_over` rises with `shots_left = 0`.

## Test plan
- Reset with `start_btn` held high, then release `rst_n`: state stays IDLE, no `start_new_game`. Then release and press start: `start_new_game` pulses exactly once, 1 cycle after the edge; `round_active` rises 3 cycles after the edge.
- Set cursor equal to target, press fire: `result_valid` and `hit = 1` one cycle later; `score` 0→1, `shots_left` 8→7; `start_new_game` coincides with `result_valid`; target changes the following cycle.
- `ROUND_FRAMES = 3`, no fire: on the 3rd `frame_tick` in AIM, RESOLVE with `hit = 0`; `score` unchanged.
- Fire edge and final timeout `frame_tick` in the same cycle, cursor on target: `hit = 1`.
- `SHOTS_PER_GAME = 2`, two hits: the final RESOLVE has no `start_new_game`; `game_over = 1`, `score = 2`, `shots_left = 0`. Fire in OVER is ignored. Start gives `score = 0`, `shots_left = 2`, LOAD.
- Drop `ena` for 5 cycles while in RESOLVE: `result_valid` low while disabled, then exactly one `result_valid` pulse after `ena` returns; `score` increments exactly once.
